stdmacro_skid_ctrl: RTL and testbench
=====================================

# stdmacro_skid_ctrl

Two-entry valid/ready skid-buffer controller for the pipeline-register datapath. It sequences a main register and a skid register from a small state machine, so any pipeline boundary can be cut with full throughput and no combinational path from `m_ready` to `s_ready`. It sits between any producer/consumer stage pair in the core and replaces hand-written stall logic around plain pipeline registers.

## Interface
Parameters:
- `DATA_WIDTH`, 32, payload width in bits.
- `DATA_RESET_VALUE`, 'b0, reset value of both payload registers and of `m_data`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous flush; empties the buffer.
- `s_valid`  in  1  upstream payload valid.
- `s_ready`  out  1  upstream may transfer; decoded from state register only.
- `s_data`  in  DATA_WIDTH  upstream payload.
- `m_valid`  out  1  downstream payload valid.
- `m_ready`  in  1  downstream accepts.
- `m_data`  out  DATA_WIDTH  downstream payload, driven directly by the main register.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Upstream transfer = `s_valid & s_ready`. Downstream transfer = `m_valid & m_ready`.
- States: EMPTY (0 entries), BUSY (main holds 1 entry), FULL (main and skid hold 1 entry each; skid is younger).
- Decoded outputs:
  - `s_ready` = (state != FULL).
  - `m_valid` = (state != EMPTY).
  - `occupancy` = 0/1/2 for EMPTY/BUSY/FULL.
- Transitions and register enables (`main_en`, `skid_en`):
  - EMPTY and `s_valid`: main <= `s_data`, go to BUSY.
  - EMPTY and not `s_valid`: stay.
  - BUSY, in and out: main <= `s_data`, stay in BUSY.
  - BUSY, in only: skid <= `s_data`, go to FULL.
  - BUSY, out only: go to EMPTY. Main keeps its stale value and `m_valid`=0.
  - BUSY, neither: stay.
  - FULL and `m_ready`: main <= skid, go to BUSY. No upstream transfer is possible because `s_ready`=0.
  - FULL and not `m_ready`: stay.
- Main input mux = FULL ? skid_q : `s_data`.
- Skid is written only on the BUSY "in only" transition.
- `flush` (priority below `reset`, above all transitions):
  - Next state is EMPTY.
  - Any transfers in the flush cycle are dropped by both sides.
  - Payload registers are not cleared.
- `reset`:
  - Next state is EMPTY and both payload registers take `DATA_RESET_VALUE`.
  - Handshakes in reset cycles are ignored.
  - Reset mid-operation discards held entries silently.
- Ordering: strict FIFO. Data is never duplicated or dropped except by `flush`/`reset`.

## Timing
- Reset values:
  - `s_ready`=1.
  - `m_valid`=0.
  - `occupancy`=0.
  - `m_data`=`DATA_RESET_VALUE`.
- Latency: 1 cycle from upstream transfer to `m_valid` (EMPTY case).
- Throughput: 1 transfer per cycle in steady state with `m_ready` held at 1.
- `s_ready`, `m_valid`, `m_data` and `occupancy` are pure register outputs, with no input-to-output combinational path.
- After `m_ready` rises in FULL, `s_ready` returns to 1 on the next cycle.
- The first cycle after `reset` or `flush` deasserts is EMPTY with `s_ready`=1.

## Structure
- Shared package `stdmacro_skid_pkg`:
  - State encoding constants EMPTY=2'd0, BUSY=2'd1, FULL=2'd2. State 2'd3 is illegal and recovers to EMPTY.
  - Occupancy width constant.
- One natural sub-module, `stdmacro_skid_reg`:
  - Enabled register with synchronous active-high reset, `DATA_WIDTH`/`DATA_RESET_VALUE` parameters.
  - Instantiated twice, as main and skid.
- The state machine and enable/mux logic stay in the top module.

## Test plan
- Reset then idle:
  - During and after `reset` → `s_ready`=1, `m_valid`=0, `occupancy`=0, `m_data`=`DATA_RESET_VALUE`.
- Streaming:
  - `m_ready`=1, push 0x11,0x22,0x33 on consecutive cycles → same values on `m_data` one cycle later each, `occupancy` stays 1, `s_ready` never drops.
- Backpressure:
  - `m_ready`=0, push 0xA1,0xA2 → `occupancy`=2, `s_ready`=0, `m_data`=0xA1.
  - Then `m_ready`=1 for 2 cycles → 0xA1 then 0xA2 delivered, `occupancy`=0, `s_ready`=1.
- Simultaneous in/out in BUSY:
  - Holding 0x05, push 0x06 with `m_ready`=1 → 0x05 consumed, `m_data`=0x06 next cycle, `occupancy` stays 1.
- Flush in FULL:
  - FULL with 0xB1/0xB2, assert `flush` with `s_valid`=1, `m_ready`=1 → next cycle `m_valid`=0, `occupancy`=0, neither 0xB1 nor the new payload delivered afterwards.
- Reset mid-operation:
  - BUSY holding 0xC3, assert `reset` one cycle → EMPTY, `m_data`=`DATA_RESET_VALUE`, 0xC3 never re-emerges.
- Random soak:
  - Random `s_valid`/`m_ready`, scoreboard compares order → zero mismatches.

Source files
------------

// File: rtl/stdmacro_skid_pkg.sv
// rtl/stdmacro_skid_pkg.sv - shared constants and helpers for the skid-buffer controller
//
// Purpose: state encoding, occupancy width and the state-to-occupancy decode
//          shared by stdmacro_skid_ctrl and its bench.
// Contents:
//   STATE_WIDTH / OCC_WIDTH        widths of the state register and occupancy port
//   ST_EMPTY / ST_BUSY / ST_FULL   legal state encodings (2'd3 is illegal)
//   occ_of_state()                 entry count held in a given state
package stdmacro_skid_pkg;

  localparam int STATE_WIDTH = 2;
  localparam int OCC_WIDTH   = 2;

  localparam logic [STATE_WIDTH-1:0] ST_EMPTY = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ST_BUSY  = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ST_FULL  = 2'd2;

  // The illegal encoding reports zero entries so it never advertises data.
  function automatic logic [OCC_WIDTH-1:0] occ_of_state(input logic [STATE_WIDTH-1:0] st);
    case (st)
      ST_BUSY: return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/stdmacro_skid_reg.sv
// rtl/stdmacro_skid_reg.sv - enabled payload register with synchronous reset
//
// Purpose: one payload slot of the skid buffer (used as main and as skid).
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, loads DATA_RESET_VALUE
//   en     in   load enable
//   d      in   DATA_WIDTH next payload
//   q      out  DATA_WIDTH held payload
module stdmacro_skid_reg
  import stdmacro_skid_pkg::*;
#(
  parameter int                    DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= DATA_RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/stdmacro_skid_ctrl.sv
// rtl/stdmacro_skid_ctrl.sv - two-entry valid/ready skid-buffer controller
//
// Purpose: cuts a valid/ready pipeline boundary with full throughput. A main
//          register drives the downstream side; a skid register absorbs the one
//          extra beat accepted while downstream stalls. All outputs decode from
//          registers only, so there is no m_ready -> s_ready combinational path.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   flush      in   synchronous flush, empties the buffer without clearing payloads
//   s_valid    in   upstream payload valid
//   s_ready    out  upstream may transfer
//   s_data     in   DATA_WIDTH upstream payload
//   m_valid    out  downstream payload valid
//   m_ready    in   downstream accepts
//   m_data     out  DATA_WIDTH downstream payload (main register)
//   occupancy  out  2 held entries, 0..2
module stdmacro_skid_ctrl
  import stdmacro_skid_pkg::*;
#(
  parameter int                    DATA_WIDTH       = 32,
  parameter logic [DATA_WIDTH-1:0] DATA_RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  logic [STATE_WIDTH-1:0] state_q;
  logic [STATE_WIDTH-1:0] state_d;
  logic                   main_en;
  logic                   skid_en;
  logic                   in_xfer;
  logic                   out_xfer;
  logic [DATA_WIDTH-1:0]  main_d;
  logic [DATA_WIDTH-1:0]  skid_q;

  // Output decode depends on state_q alone.
  assign s_ready   = (state_q != ST_FULL);
  assign m_valid   = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign occupancy = occ_of_state(state_q);

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  // When FULL the older beat is in main, so main refills from skid to keep order.
  assign main_d = (state_q == ST_FULL) ? skid_q : s_data;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (s_valid) begin
            main_en = 1'b1;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          case ({in_xfer, out_xfer})
            2'b11: main_en = 1'b1;
            2'b10: begin
              skid_en = 1'b1;
              state_d = ST_FULL;
            end
            2'b01: state_d = ST_EMPTY;  // main keeps the consumed value
            default: state_d = ST_BUSY;
          endcase
        end
        ST_FULL: begin
          if (m_ready) begin
            main_en = 1'b1;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;  // illegal encoding recovers
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  stdmacro_skid_reg #(
    .DATA_WIDTH       (DATA_WIDTH),
    .DATA_RESET_VALUE (DATA_RESET_VALUE)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (m_data)
  );

  stdmacro_skid_reg #(
    .DATA_WIDTH       (DATA_WIDTH),
    .DATA_RESET_VALUE (DATA_RESET_VALUE)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (s_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_stdmacro_skid_ctrl.sv
// tb/tb_stdmacro_skid_ctrl.sv - self-checking bench for stdmacro_skid_ctrl
module tb_stdmacro_skid_ctrl;

  localparam int          DW  = 16;
  localparam logic [15:0] RST = 16'h5A5A;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occupancy;

  int errors = 0;
  int checks = 0;

  // Reference: a FIFO of held entries (capacity 2) plus the last payload that
  // reached the head, which is what the downstream port shows when empty.
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] mdl_main;
  logic [DW-1:0] exp_dlv[$];
  logic [DW-1:0] got_q[$];

  stdmacro_skid_ctrl #(
    .DATA_WIDTH       (DW),
    .DATA_RESET_VALUE (RST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // Called at a falling edge: drives one cycle of inputs, records what the
  // consumer takes, advances the reference, and returns at the next falling edge.
  task automatic cycle(input logic sv, input logic [DW-1:0] sd, input logic mr,
                       input logic fl, input logic rs);
    bit rdy;
    s_valid = sv; s_data = sd; m_ready = mr; flush = fl; reset = rs;
    #1;
    if (m_valid === 1'b1 && mr && !fl && !rs) got_q.push_back(m_data);
    if (rs) begin
      mdl_q.delete();
      mdl_main = RST;
    end else if (fl) begin
      mdl_q.delete();
    end else begin
      rdy = (mdl_q.size() < 2);
      if (mr && mdl_q.size() > 0) exp_dlv.push_back(mdl_q.pop_front());
      if (sv && rdy) mdl_q.push_back(sd);
      if (mdl_q.size() > 0) mdl_main = mdl_q[0];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_lists();
    got_q.delete();
    exp_dlv.delete();
  endtask

  task automatic test_reset();
    cycle(1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 16'h4321, 1'b1, 1'b0, 1'b1);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (m_data !== RST) begin errors++; $display("FAIL reset_m_data: got %h expected %h", m_data, RST); end
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    checks++; if (s_ready !== 1'b1 || m_valid !== 1'b0 || occupancy !== 2'd0 || m_data !== RST) begin
      errors++; $display("FAIL idle_after_reset: got rdy=%b vld=%b occ=%0d data=%h expected 1 0 0 %h",
                         s_ready, m_valid, occupancy, m_data, RST);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] vals[3];
    vals[0] = 16'h11; vals[1] = 16'h22; vals[2] = 16'h33;
    clear_lists();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, vals[i], 1'b1, 1'b0, 1'b0);
      checks++; if (m_data !== vals[i] || occupancy !== 2'd1 || s_ready !== 1'b1 || m_valid !== 1'b1) begin
        errors++; $display("FAIL stream_beat%0d: got data=%h occ=%0d rdy=%b vld=%b expected %h 1 1 1",
                           i, m_data, occupancy, s_ready, m_valid, vals[i]);
      end
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain_occ: got %0d expected 0", occupancy); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL stream_count: got %0d expected 3", got_q.size()); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (got_q[i] !== vals[i]) begin errors++; $display("FAIL stream_order%0d: got %h expected %h", i, got_q[i], vals[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_lists();
    cycle(1'b1, 16'hA1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hA2, 1'b0, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd2 || s_ready !== 1'b0 || m_data !== 16'hA1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL bp_full: got occ=%0d rdy=%b data=%h vld=%b expected 2 0 a1 1", occupancy, s_ready, m_data, m_valid);
    end
    cycle(1'b1, 16'hEE, 1'b1, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd1 || s_ready !== 1'b1 || m_data !== 16'hA2) begin
      errors++; $display("FAIL bp_release: got occ=%0d rdy=%b data=%h expected 1 1 a2", occupancy, s_ready, m_data);
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (occupancy !== 2'd0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty: got occ=%0d rdy=%b vld=%b expected 0 1 0", occupancy, s_ready, m_valid);
    end
    checks++; if (got_q.size() != 2 || got_q[0] !== 16'hA1 || got_q[1] !== 16'hA2) begin
      errors++; $display("FAIL bp_order: got %0d beats expected 2 beats a1,a2", got_q.size());
    end
  endtask

  task automatic test_simultaneous();
    clear_lists();
    cycle(1'b1, 16'h05, 1'b0, 1'b0, 1'b0);
    checks++; if (m_data !== 16'h05 || occupancy !== 2'd1) begin
      errors++; $display("FAIL simul_hold: got data=%h occ=%0d expected 05 1", m_data, occupancy);
    end
    cycle(1'b1, 16'h06, 1'b1, 1'b0, 1'b0);
    checks++; if (m_data !== 16'h06 || occupancy !== 2'd1 || s_ready !== 1'b1) begin
      errors++; $display("FAIL simul_swap: got data=%h occ=%0d rdy=%b expected 06 1 1", m_data, occupancy, s_ready);
    end
    checks++; if (got_q.size() != 1 || got_q[0] !== 16'h05) begin
      errors++; $display("FAIL simul_consumed: got %0d beats expected one beat 05", got_q.size());
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    clear_lists();
    cycle(1'b1, 16'hB1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hB2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hB3, 1'b1, 1'b1, 1'b0);
    checks++; if (m_valid !== 1'b0 || occupancy !== 2'd0 || s_ready !== 1'b1) begin
      errors++; $display("FAIL flush_state: got vld=%b occ=%0d rdy=%b expected 0 0 1", m_valid, occupancy, s_ready);
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (got_q.size() != 0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dropped: got %0d beats vld=%b expected 0 beats vld=0", got_q.size(), m_valid);
    end
    checks++; if (m_data !== 16'hB1) begin errors++; $display("FAIL flush_payload_kept: got %h expected b1", m_data); end
  endtask

  task automatic test_reset_mid();
    clear_lists();
    cycle(1'b1, 16'hC3, 1'b0, 1'b0, 1'b0);
    checks++; if (m_data !== 16'hC3 || occupancy !== 2'd1) begin
      errors++; $display("FAIL rmid_hold: got data=%h occ=%0d expected c3 1", m_data, occupancy);
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    checks++; if (occupancy !== 2'd0 || m_data !== RST || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_state: got occ=%0d data=%h rdy=%b vld=%b expected 0 %h 1 0",
                         occupancy, m_data, s_ready, m_valid, RST);
    end
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rmid_no_reemerge: got %0d beats expected 0", got_q.size()); end
  endtask

  task automatic test_random_soak();
    int cyc_errs;
    cyc_errs = 0;
    clear_lists();
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0), 1'b0);
      checks++;
      if (occupancy !== 2'(mdl_q.size()) || s_ready !== (mdl_q.size() < 2) ||
          m_valid !== (mdl_q.size() > 0) || m_data !== mdl_main) begin
        errors++; cyc_errs++;
        if (cyc_errs <= 5)
          $display("FAIL soak_cycle%0d: got occ=%0d rdy=%b vld=%b data=%h expected occ=%0d data=%h",
                   i, occupancy, s_ready, m_valid, m_data, mdl_q.size(), mdl_main);
      end
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checks++; if (got_q.size() != exp_dlv.size() || exp_dlv.size() == 0) begin
      errors++; $display("FAIL soak_count: got %0d beats expected %0d", got_q.size(), exp_dlv.size());
    end else begin
      for (int i = 0; i < exp_dlv.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_dlv[i]) begin
          errors++; $display("FAIL soak_order%0d: got %h expected %h", i, got_q[i], exp_dlv[i]);
          break;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    mdl_main = RST;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    test_random_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
